// File: rtl/rv32i_fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch unit: datapath width, default
// reset PC, the NOP driven on a fetch fault, and the fetch FSM state type.
package rv32i_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CAP,
    OUT,
    FLT,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Bus bundle around the fetch unit: the paired-read port to the 16-bit
// banked instruction memory, the valid/ready instruction port to decode,
// and the redirect port from execute.
//   master : the fetch unit (drives memory reads, instruction outputs)
//   slave  : the environment (memory, decode and execute side)
interface rv32i_fetch_unit_if;
  import rv32i_fetch_pkg::*;

  // instruction memory read port
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_rd_addr;
  logic [XLEN-1:0] mem_rd_data;
  logic            mem_rd_valid;

  // decode handshake
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fault;

  // redirect from execute
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output mem_rd_en, mem_rd_addr, instr_valid, instr, instr_pc, fault,
    input  mem_rd_data, mem_rd_valid, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, instr_valid, instr, instr_pc, fault,
    output mem_rd_data, mem_rd_valid, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch unit: holds the PC, issues two-cycle paired reads to the
// 16-bit banked instruction memory, captures the 32-bit instruction and
// presents it to decode over valid/ready. Accepts branch/jump/trap
// redirects from execute. Misaligned or out-of-range PCs raise a fetch
// fault (NOP presented with fault=1) and the unit halts until redirected.
// Ports:
//   i_clk      clock, posedge
//   i_rst_n    asynchronous active-low reset
//   i_fetch_en 1 = allowed to start a new read pair from IDLE
//   bus        rv32i_fetch_unit_if.master (memory, decode, redirect)
module rv32i_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     IMEM_WORDS = 128,
  parameter logic [XLEN-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fetch_en,
  rv32i_fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] PC_LIMIT = IMEM_WORDS * 4;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] redir_pc;
  logic            redir_pend;

  logic            fault_chk;
  logic [XLEN-1:0] squash_tgt;

  assign fault_chk = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);

  // A redirect arriving in CAP itself is newer than any pending one.
  assign squash_tgt = bus.redirect_valid ? bus.redirect_pc : redir_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pc_q       <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      redir_pc   <= '0;
      redir_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
          end else if (fault_chk) begin
            instr_q <= NOP_INSTR;
            pc_q    <= pc;
            state   <= FLT;
          end else if (i_fetch_en) begin
            addr_q <= pc;
            state  <= RD0;
          end
        end
        // A pair is never aborted: an odd rd_en count would desync the
        // memory's half-select, so redirects here are only latched.
        RD0: begin
          if (bus.redirect_valid) begin
            redir_pc   <= bus.redirect_pc;
            redir_pend <= 1'b1;
          end
          state <= RD1;
        end
        RD1: begin
          assert (bus.mem_rd_valid)
            else $error("rv32i_fetch_unit: mem_rd_valid low in second read cycle");
          if (bus.redirect_valid) begin
            redir_pc   <= bus.redirect_pc;
            redir_pend <= 1'b1;
          end
          state <= CAP;
        end
        CAP: begin
          if (redir_pend || bus.redirect_valid) begin
            pc         <= squash_tgt;
            redir_pend <= 1'b0;
            state      <= IDLE;
          end else begin
            instr_q <= bus.mem_rd_data;
            pc_q    <= pc;
            pc      <= pc + 32'd4;
            state   <= OUT;
          end
        end
        OUT: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= IDLE;
          end else if (bus.instr_ready) begin
            state <= IDLE;
          end
        end
        FLT: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= IDLE;
          end else if (bus.instr_ready) begin
            state <= HALT;
          end
        end
        HALT: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en   = (state == RD0) || (state == RD1);
  assign bus.mem_rd_addr = addr_q;
  assign bus.instr_valid = (state == OUT) || (state == FLT);
  assign bus.fault       = (state == FLT);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = pc_q;

endmodule
